// File: rtl/serial_cmd_pkg.sv
// rtl/serial_cmd_pkg.sv - shared types and constants for the serial command engine
// Contents: opcode/state enums, command word field positions, response tags
// and helpers that build the response words.
package serial_cmd_pkg;

  typedef enum logic [3:0] {
    OP_PING  = 4'h0,
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_BURST = 4'h3
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RD,
    ST_RESP
  } state_t;

  // Command word layout
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int CNT_MSB  = 23;
  localparam int CNT_LSB  = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  // Response tags
  localparam logic [15:0] PING_TAG = 16'h5A5A;
  localparam logic [3:0]  ACK_TAG  = 4'hA;
  localparam logic [15:0] ERR_TAG  = 16'hEEEE;

  function automatic logic [31:0] ping_word(input logic [15:0] addr);
    return {PING_TAG, addr};
  endfunction

  function automatic logic [31:0] ack_word(input logic [15:0] addr);
    return {ACK_TAG, 12'h000, addr};
  endfunction

  function automatic logic [31:0] err_word(input logic [3:0] op);
    return {ERR_TAG, 12'h000, op};
  endfunction

endpackage

// File: rtl/serial_cmd_ram.sv
// rtl/serial_cmd_ram.sv - single-port word RAM with registered read
// Ports:
//   clk   - system clock
//   we    - write enable; when low the cycle is a read
//   addr  - word index
//   wdata - write data
//   rdata - read data, valid one cycle after the read is issued
module serial_cmd_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Write and read are exclusive so this maps onto one BRAM port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/serial_cmd_engine.sv
// rtl/serial_cmd_engine.sv - word-level memory command processor
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   s_data/s_valid/s_ready - incoming command and write-data words
//   m_data/m_valid/m_ready - outgoing response words
// One command is in flight at a time; the single m_data register is the
// only response storage, so the input stalls until a response drains.
module serial_cmd_engine
  import serial_cmd_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready
);

  state_t            state;
  logic [7:0]        remaining;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       cmd_addr;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  logic [3:0]        op;
  logic [7:0]        cnt;
  logic [15:0]       addr;
  logic [ADDR_W-1:0] addr_idx;
  logic [ADDR_W-1:0] idx_next;
  logic              s_fire;
  logic              unused_bits;

  assign op       = s_data[OP_MSB:OP_LSB];
  assign cnt      = s_data[CNT_MSB:CNT_LSB];
  assign addr     = s_data[ADDR_MSB:ADDR_LSB];
  assign addr_idx = addr[ADDR_W-1:0];
  // Width of idx makes the burst index wrap modulo DEPTH for free.
  assign idx_next = idx + 1'b1;

  assign unused_bits = ^s_data[27:24];

  assign s_ready = !rst && (state == ST_IDLE || state == ST_WDATA);
  assign s_fire  = s_valid && s_ready;

  // RAM port steering: reads are issued on command accept (IDLE) and on
  // each burst-advancing handshake (RESP); writes only on the data word.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = idx;
    case (state)
      ST_IDLE:  ram_addr = addr_idx;
      ST_WDATA: ram_we   = s_fire;
      ST_RESP:  ram_addr = idx_next;
      default:  ram_addr = idx;
    endcase
  end

  serial_cmd_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(s_data),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      m_valid   <= 1'b0;
      m_data    <= 32'h0;
      remaining <= 8'h0;
      idx       <= '0;
      cmd_addr  <= 16'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_fire) begin
            cmd_addr  <= addr;
            idx       <= addr_idx;
            remaining <= 8'h0;
            case (op)
              OP_PING: begin
                m_data  <= ping_word(addr);
                m_valid <= 1'b1;
                state   <= ST_RESP;
              end
              OP_WRITE: begin
                state <= ST_WDATA;
              end
              OP_READ: begin
                state <= ST_RD;
              end
              OP_BURST: begin
                remaining <= cnt;
                state     <= ST_RD;
              end
              default: begin
                m_data  <= err_word(op);
                m_valid <= 1'b1;
                state   <= ST_RESP;
              end
            endcase
          end
        end
        ST_WDATA: begin
          // The RAM write happens this same cycle, so the ACK is never
          // ahead of the stored data.
          if (s_fire) begin
            m_data  <= ack_word(cmd_addr);
            m_valid <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RD: begin
          m_data  <= ram_rdata;
          m_valid <= 1'b1;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (remaining != 8'h0) begin
              remaining <= remaining - 8'h1;
              idx       <= idx_next;
              state     <= ST_RD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_engine.sv
// tb/tb_serial_cmd_engine.sv - randomized self-checking bench for serial_cmd_engine
module tb_serial_cmd_engine;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];

  serial_cmd_engine #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_for_send", {31'd0, s_ready}, 32'd1);
    if (s_ready === 1'b1) @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
  endtask

  // Waits for a response, optionally holds m_ready low (with junk input
  // offered), then completes the handshake.
  task automatic get_resp(input int exp_lat, input int hold, input logic [31:0] exp,
                          input string tag);
    int n;
    logic [31:0] first;
    n = 0;
    while (m_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, m_data, exp);
    check({tag, "_s_ready_busy"}, {31'd0, s_ready}, 32'd0);
    first = m_data;
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, m_valid}, 32'd1);
      check({tag, "_hold_data"}, m_data, first);
      check({tag, "_hold_s_ready"}, {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
  endtask

  // Reference model: derive the response list from the command rules.
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] data, input int hold);
    logic [3:0]  op;
    logic [15:0] addr;
    int          idx;
    int          lat;
    logic [31:0] exp_q [$];
    op   = cmd[31:28];
    addr = cmd[15:0];
    idx  = int'(addr) % DEPTH;
    lat  = 0;
    case (op)
      4'h0: exp_q.push_back(32'h5A5A_0000 | {16'h0, addr});
      4'h1: begin
        ref_mem[idx] = data;
        exp_q.push_back(32'hA000_0000 | {16'h0, addr});
      end
      4'h2: begin
        exp_q.push_back(ref_mem[idx]);
        lat = 1;
      end
      4'h3: begin
        for (int k = 0; k <= int'(cmd[23:16]); k++)
          exp_q.push_back(ref_mem[(idx + k) % DEPTH]);
        lat = 1;
      end
      default: exp_q.push_back(32'hEEEE_0000 | {28'h0, op});
    endcase
    send_word(cmd);
    if (op == 4'h1) send_word(data);
    for (int k = 0; k < exp_q.size(); k++)
      get_resp(lat, (k == 0) ? hold : 0, exp_q[k], $sformatf("op%0h_w%0d", op, k));
    check($sformatf("op%0h_idle_s_ready", op), {31'd0, s_ready}, 32'd1);
    check($sformatf("op%0h_idle_m_valid", op), {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] cmd;
    int          r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_data", m_data, 32'd0);
    check("reset_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(32'h0000_1234, 32'h0, 0);

    // Fill the RAM so every later read has a known value.
    for (int i = 0; i < DEPTH; i++)
      run_cmd({4'h1, 4'h0, 8'($urandom), 8'($urandom), 8'(i)}, $urandom, 0);

    run_cmd(32'h1000_0005, 32'hDEAD_BEEF, 0);
    run_cmd(32'h2000_0005, 32'h0, 0);
    run_cmd(32'h1000_00FE, 32'h0000_0011, 0);
    run_cmd(32'h1000_00FF, 32'h0000_0022, 0);
    run_cmd(32'h1000_0000, 32'h0000_0033, 0);
    run_cmd(32'h3002_00FE, 32'h0, 0);
    run_cmd(32'h7000_0000, 32'h0, 0);
    run_cmd(32'h2000_0105, 32'h0, 0);
    run_cmd(32'h2000_0005, 32'h0, 20);

    // Reset between a WRITE command and its data word.
    send_word(32'h1000_0009);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(32'h2000_0009, 32'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 8);
      case (r)
        0, 1:    op = 4'h0;
        2, 3:    op = 4'h1;
        4, 5:    op = 4'h2;
        6, 7:    op = 4'h3;
        default: op = 4'($urandom_range(4, 15));
      endcase
      cmd = {op, 4'($urandom), 8'($urandom), 16'($urandom)};
      if (op == 4'h3) cmd[23:16] = 8'($urandom_range(0, 5));
      run_cmd(cmd, $urandom, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
